imm_extend_stage: RTL and testbench

Registered, flow-controlled immediate-generation stage for the decode path. Accepts a 32-bit instruction word, immediate-format selector and PC; produces the sign/zero-extended immediate at XLEN width, plus the PC-relative target `pc + immop`. A 2-entry skid buffer gives a valid/ready interface with a registered `in_ready`, so it sits between fetch and execute without combinational ready paths.

---
 rtl/imm_pkg.sv | 22 ++
 rtl/imm_decode.sv | 38 +++
 rtl/imm_extend_stage.sv | 119 +++++++++++
 tb/tb_imm_extend_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation stage: format encodings and
// the skid-buffer occupancy states.
package imm_pkg;

  localparam int IMMSRC_W = 3;

  typedef enum logic [IMMSRC_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } immsrc_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: slices the instruction word per format
// and sign/zero-extends the result to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]         instr_i,
  input  logic [IMMSRC_W-1:0] immsrc_i,
  output logic [XLEN-1:0]     immop_o,
  output logic                illegal_o
);

  logic        sign;
  logic signed [31:0] imm32;

  assign sign = instr_i[31];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    imm32     = '0;
    illegal_o = 1'b0;
    case (immsrc_i)
      IMM_I:   imm32 = {{20{sign}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{sign}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{sign}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J:   imm32 = {{11{sign}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_Z:   imm32 = {27'b0, instr_i[19:15]};
      default: illegal_o = 1'b1;
    endcase
  end

  // Every format is fully formed in 32 bits; a signed size cast widens to XLEN.
  // Z has bit 31 clear, so it stays zero-extended.
  assign immop_o = XLEN'(imm32);

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate stage: decode and PC-relative add feed a 2-entry skid
// buffer whose in_ready depends only on occupancy, never on out_ready.
module imm_extend_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [IMMSRC_W-1:0] immsrc,
  input  logic [XLEN-1:0]     pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     immop,
  output logic [XLEN-1:0]     target,
  output logic                illegal
);

  typedef struct packed {
    logic [XLEN-1:0] immop;
    logic [XLEN-1:0] target;
    logic            illegal;
  } imm_entry_t;

  buf_state_e state_q, state_d;
  imm_entry_t head_q, head_d;
  imm_entry_t tail_q, tail_d;
  imm_entry_t entry_in;
  logic [XLEN-1:0] dec_immop;
  logic            dec_illegal;
  logic            accept;
  logic            drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (instr),
    .immsrc_i  (immsrc),
    .immop_o   (dec_immop),
    .illegal_o (dec_illegal)
  );

  assign entry_in.immop   = dec_immop;
  assign entry_in.target  = pc + dec_immop;
  assign entry_in.illegal = dec_illegal;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= BUF_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (accept) state_d = BUF_ONE;
        BUF_ONE: begin
          if (accept && !drain)      state_d = BUF_FULL;
          else if (!accept && drain) state_d = BUF_EMPTY;
        end
        BUF_FULL:  if (drain) state_d = BUF_ONE;
        default:   state_d = BUF_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      BUF_ONE:  out_valid = 1'b1;
      BUF_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Head is the oldest entry; tail only fills when the head is held.
  // A flush forces EMPTY, so whatever lands in the slots that cycle is dead.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      BUF_EMPTY: if (accept) head_d = entry_in;
      BUF_ONE: begin
        if (accept && drain) head_d = entry_in;
        else if (accept)     tail_d = entry_in;
      end
      BUF_FULL:  if (drain) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the two data slots are reset because the head drives the outputs, which must read 0 in reset.
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign immop   = head_q.immop;
  assign target  = head_q.target;
  assign illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: XLEN=32 and XLEN=64 instances share stimulus;
// a queue-based reference model predicts the head entry every cycle.
module tb_imm_extend_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic [63:0] pc;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] immop32, target32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] immop64, target64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  exp_t mq[$];

  imm_extend_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .pc(pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready),
    .immop(immop32), .target(target32), .illegal(illegal32)
  );

  imm_extend_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .pc(pc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .immop(immop64), .target(target64), .illegal(illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference immediate, built arithmetically from field weights.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
    longint s, sgn, hi, v;
    s   = longint'($signed(ins));
    sgn = s >>> 31;
    v   = 0;
    case (src)
      3'd0: v = s >>> 20;
      3'd1: begin
        hi = s >>> 25;
        v  = hi * 32 + longint'(ins[11:7]);
      end
      3'd2: v = sgn * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
              + longint'(ins[11:8]) * 2;
      3'd3: v = sgn * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
              + longint'(ins[30:21]) * 2;
      3'd4: begin
        hi = s >>> 12;
        v  = hi * 4096;
      end
      3'd5: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    return v;
  endfunction

  // Model: FIFO of depth 2, flush and reset empty it.
  always @(posedge clk or negedge rst_n) begin : model
    int   n;
    exp_t e;
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      n     = mq.size();
      e.imm = ref_imm(instr, immsrc);
      e.tgt = pc + e.imm;
      e.ill = (immsrc > 3'd5);
      if (out_ready && n > 0) void'(mq.pop_front());
      if (in_valid && n < 2) mq.push_back(e);
    end
  end

  task automatic push(input logic [31:0] ins, input logic [2:0] src, input logic [63:0] p);
    in_valid = 1'b1;
    instr    = ins;
    immsrc   = src;
    pc       = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || immop32 !== '0 || target32 !== '0 ||
        illegal32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1 ||
        immop64 !== '0 || target64 !== '0 || illegal64 !== 1'b0) begin
      errors++;
      $display("FAIL reset: v32=%b r32=%b imm32=%h t32=%h v64=%b r64=%b imm64=%h t64=%h, want v=0 r=1 data=0",
               out_valid32, in_ready32, immop32, target32, out_valid64, in_ready64, immop64, target64);
    end
  endtask

  task automatic test_vectors;
    out_ready = 1'b1;
    push(32'hFFF00093, 3'd0, 64'h0);
    checks++;
    if (out_valid32 !== 1'b1 || immop32 !== 32'hFFFFFFFF || target32 !== 32'hFFFFFFFF || illegal32 !== 1'b0) begin
      errors++;
      $display("FAIL imm_i32: v=%b imm=%h tgt=%h ill=%b, want 1 ffffffff ffffffff 0",
               out_valid32, immop32, target32, illegal32);
    end
    push(32'hFE000EE3, 3'd2, 64'h100);
    checks++;
    if (out_valid32 !== 1'b1 || immop32 !== 32'hFFFFFFFC || target32 !== 32'h000000FC) begin
      errors++;
      $display("FAIL imm_b32: v=%b imm=%h tgt=%h, want 1 fffffffc 000000fc", out_valid32, immop32, target32);
    end
    push(32'h0080006F, 3'd3, 64'h200);
    checks++;
    if (out_valid32 !== 1'b1 || immop32 !== 32'h00000008 || target32 !== 32'h00000208) begin
      errors++;
      $display("FAIL imm_j32: v=%b imm=%h tgt=%h, want 1 00000008 00000208", out_valid32, immop32, target32);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: v32=%b v64=%b, want 0 0", out_valid32, out_valid64);
    end
    push(32'h800000B7, 3'd4, 64'h0);
    checks++;
    if (immop64 !== 64'hFFFFFFFF80000000 || target64 !== 64'hFFFFFFFF80000000 || immop32 !== 32'h80000000) begin
      errors++;
      $display("FAIL imm_u64: imm64=%h tgt64=%h imm32=%h, want ffffffff80000000 ffffffff80000000 80000000",
               immop64, target64, immop32);
    end
    push(32'h000FD073, 3'd5, 64'h10);
    checks++;
    if (immop64 !== 64'h1F || target64 !== 64'h2F || illegal64 !== 1'b0) begin
      errors++;
      $display("FAIL imm_z64: imm=%h tgt=%h ill=%b, want 1f 2f 0", immop64, target64, illegal64);
    end
    push(32'hFFFFFFFF, 3'd7, 64'hDEADBEEF00001234);
    checks++;
    if (immop64 !== '0 || target64 !== 64'hDEADBEEF00001234 || illegal64 !== 1'b1 ||
        target32 !== 32'h00001234 || illegal32 !== 1'b1) begin
      errors++;
      $display("FAIL reserved: imm=%h tgt=%h ill=%b tgt32=%h ill32=%b, want 0 deadbeef00001234 1 00001234 1",
               immop64, target64, illegal64, target32, illegal32);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [63:0] got[$];
    logic        c_taken;
    out_ready = 1'b0;
    push(32'h0, 3'd0, 64'h1000);
    push(32'h0, 3'd0, 64'h2000);
    checks++;
    if (in_ready64 !== 1'b0 || in_ready32 !== 1'b0 || target64 !== 64'h1000) begin
      errors++;
      $display("FAIL full_ready: r64=%b r32=%b head=%h, want 0 0 1000", in_ready64, in_ready32, target64);
    end
    in_valid = 1'b1;
    pc       = 64'h3000;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready64 !== 1'b0 || out_valid64 !== 1'b1 || target64 !== 64'h1000) begin
      errors++;
      $display("FAIL hold_stable: r=%b v=%b head=%h, want 0 1 1000", in_ready64, out_valid64, target64);
    end
    out_ready = 1'b1;
    c_taken   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (in_ready64 !== 1'b1) begin
          errors++;
          $display("FAIL ready_rise: r=%b, want 1", in_ready64);
        end
      end
      if (out_valid64 && out_ready) got.push_back(target64);
      if (in_valid && in_ready64) c_taken = 1'b1;
      @(posedge clk);
      #1;
      if (c_taken) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL order_count: got %0d entries, want 3", got.size());
    end else if (got[0] !== 64'h1000 || got[1] !== 64'h2000 || got[2] !== 64'h3000) begin
      errors++;
      $display("FAIL order: got %h %h %h, want 1000 2000 3000", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_flush;
    logic seen;
    out_ready = 1'b0;
    push(32'h0, 3'd0, 64'h6000);
    push(32'h0, 3'd0, 64'h7000);
    flush    = 1'b1;
    in_valid = 1'b1;
    pc       = 64'h8000;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: v64=%b r64=%b v32=%b r32=%b, want 0 1 0 1",
               out_valid64, in_ready64, out_valid32, in_ready32);
    end
    out_ready = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid64 || out_valid32) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: stale output seen=%b, want 0", seen);
    end
    @(posedge clk);
    #1;
    push(32'h0, 3'd0, 64'h9000);
    checks++;
    if (out_valid64 !== 1'b1 || target64 !== 64'h9000) begin
      errors++;
      $display("FAIL post_flush: v=%b tgt=%h, want 1 9000", out_valid64, target64);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    push(32'h00100093, 3'd0, 64'h100);
    in_valid = 1'b1;
    pc       = 64'h200;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || immop64 !== '0 || target64 !== '0 ||
        illegal64 !== 1'b0 || out_valid32 !== 1'b0 || immop32 !== '0 || target32 !== '0) begin
      errors++;
      $display("FAIL async_reset: v=%b r=%b imm=%h tgt=%h ill=%b v32=%b, want 0 1 0 0 0 0",
               out_valid64, in_ready64, immop64, target64, illegal64, out_valid32);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(32'hFFF00093, 3'd0, 64'h40);
    checks++;
    if (out_valid64 !== 1'b1 || immop64 !== 64'hFFFFFFFFFFFFFFFF || target64 !== 64'h3F ||
        target32 !== 32'h3F) begin
      errors++;
      $display("FAIL reset_latency: v=%b imm=%h tgt=%h tgt32=%h, want 1 ffffffffffffffff 3f 3f",
               out_valid64, immop64, target64, target32);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic exp_v, exp_r;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      instr     = $urandom;
      immsrc    = 3'($urandom_range(0, 7));
      pc        = {$urandom, $urandom};
      @(negedge clk);
      exp_v = (mq.size() != 0);
      exp_r = (mq.size() < 2);
      checks++;
      if (out_valid64 !== exp_v || out_valid32 !== exp_v || in_ready64 !== exp_r || in_ready32 !== exp_r) begin
        errors++;
        $display("FAIL rand_flow[%0d]: v64=%b v32=%b r64=%b r32=%b, want v=%b r=%b",
                 i, out_valid64, out_valid32, in_ready64, in_ready32, exp_v, exp_r);
      end
      if (exp_v) begin
        checks++;
        if (immop64 !== mq[0].imm || target64 !== mq[0].tgt || illegal64 !== mq[0].ill ||
            immop32 !== mq[0].imm[31:0] || target32 !== mq[0].tgt[31:0] || illegal32 !== mq[0].ill) begin
          errors++;
          $display("FAIL rand_data[%0d]: imm=%h tgt=%h ill=%b imm32=%h tgt32=%h, want %h %h %b",
                   i, immop64, target64, illegal64, immop32, target32, mq[0].imm, mq[0].tgt, mq[0].ill);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    immsrc    = '0;
    pc        = '0;
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_vectors();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
